// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-ported, byte-addressed RAM between an
// instruction-side requester (port 0) and a data-side requester (port 1).
// Each port uses a req/ack handshake. Ports are granted round-robin. The
// arbiter drives the RAM's active-low strobes, waits out mem_hold on reads,
// and returns read data or an error for every transaction.
module ram_port_arbiter #(
  parameter int unsigned MAX_WAIT      = 16,            // read hold cycles tolerated, >= 1
  parameter logic [31:0] START_ADDRESS = 32'h1001_0000, // lowest legal byte address
  parameter int unsigned MEM_BYTES     = 128            // RAM size in bytes
) (
  input  logic        clk,
  input  logic        reset,

  // Port 0: instruction fetch / I-cache refill
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_bw,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,

  // Port 1: data / D-cache
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_bw,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,

  // RAM side
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_data_oe,
  input  logic [31:0] mem_rdata,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        mem_bw,
  input  logic        mem_hold
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // The wait counter only needs to reach MAX_WAIT-1: the cycle that would
  // make it MAX_WAIT is the one that aborts the read.
  localparam int unsigned       WAIT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  // Legal window, widened to 33 bits so addr+3 cannot wrap near 32'hFFFFFFFF.
  localparam logic [32:0] RANGE_LO = {1'b0, START_ADDRESS};
  localparam logic [32:0] RANGE_HI = {1'b0, START_ADDRESS} + 33'(MEM_BYTES);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic              r_last_grant;   // port granted most recently
  logic              r_grant;        // port owning the current transaction
  logic [1:0]        r_mask;         // blocks the just-served port for one IDLE cycle
  logic              r_we;           // latched direction of the current transaction
  logic [WAIT_W-1:0] r_wait_cnt;

  logic              r_p0_ack;
  logic              r_p0_err;
  logic [31:0]       r_p0_rdata;
  logic              r_p1_ack;
  logic              r_p1_err;
  logic [31:0]       r_p1_rdata;

  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_mem_data_oe;
  logic              r_mem_ce_n;
  logic              r_mem_oe_n;
  logic              r_mem_we_n;
  logic              r_mem_bw;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [1:0]        w_req;          // requests eligible this cycle
  logic              w_sel;          // port that would be granted now
  logic              w_we;
  logic              w_bw;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic [32:0]       w_addr_ext;
  logic              w_in_range;
  logic              w_capture;      // read finishes with data this cycle
  logic              w_timeout;      // read gives up this cycle
  logic              w_access_done;  // ACCESS ends on the coming edge

  // Pick the winning port, mux its request fields and range-check the address.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no path through
    // this block can leave one unassigned and infer a latch.
    w_req = {p1_req, p0_req} & ~r_mask;
    w_sel = 1'b0;
    case (w_req)
      2'b10:   w_sel = 1'b1;
      2'b11:   w_sel = ~r_last_grant;
      default: w_sel = 1'b0;
    endcase

    w_we       = w_sel ? p1_we    : p0_we;
    w_bw       = w_sel ? p1_bw    : p0_bw;
    w_addr     = w_sel ? p1_addr  : p0_addr;
    w_wdata    = w_sel ? p1_wdata : p0_wdata;

    w_addr_ext = {1'b0, w_addr};
    w_in_range = (w_addr_ext >= RANGE_LO) && ((w_addr_ext + 33'd3) < RANGE_HI);
  end

  // Decide how the ACCESS cycle ends. Writes always finish after one cycle;
  // mem_hold only matters for reads.
  always_comb begin
    w_capture     = !r_we && !mem_hold;
    w_timeout     = !r_we &&  mem_hold && (r_wait_cnt == WAIT_LAST);
    w_access_done = r_we || w_capture || w_timeout;
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM with registered RAM strobes and port responses
  // ---------------------------------------------------------------------------
  // Sequence IDLE -> ACCESS -> RESP (or IDLE -> RESP for a rejected address).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_last_grant  <= 1'b1;          // port 0 wins the first tie
      r_grant       <= 1'b0;
      r_mask        <= 2'b00;
      r_we          <= 1'b0;
      r_wait_cnt    <= '0;

      r_p0_ack      <= 1'b0;
      r_p0_err      <= 1'b0;
      r_p0_rdata    <= '0;
      r_p1_ack      <= 1'b0;
      r_p1_err      <= 1'b0;
      r_p1_rdata    <= '0;

      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_data_oe <= 1'b0;
      r_mem_ce_n    <= 1'b1;
      r_mem_oe_n    <= 1'b1;
      r_mem_we_n    <= 1'b1;
      r_mem_bw      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout: every register here sees
      // the pre-edge value of every other, whatever the statement order.
      // Ack/err are one-cycle pulses; they drop unless set below.
      r_p0_ack <= 1'b0;
      r_p0_err <= 1'b0;
      r_p1_ack <= 1'b0;
      r_p1_err <= 1'b0;

      case (r_state)
        IDLE: begin
          r_mask <= 2'b00;
          if (|w_req) begin
            r_grant      <= w_sel;
            r_last_grant <= w_sel;
            r_we         <= w_we;
            r_wait_cnt   <= '0;
            if (w_in_range) begin
              r_state    <= ACCESS;
              r_mem_addr <= w_addr;
              r_mem_bw   <= w_bw;
              r_mem_ce_n <= 1'b0;
              if (w_we) begin
                r_mem_we_n    <= 1'b0;
                r_mem_data_oe <= 1'b1;
                r_mem_wdata   <= w_wdata;
              end else begin
                r_mem_oe_n    <= 1'b0;
              end
            end else begin
              // Rejected: answer straight away without touching the RAM.
              r_state  <= RESP;
              r_p0_ack <= ~w_sel;
              r_p1_ack <=  w_sel;
              r_p0_err <= ~w_sel;
              r_p1_err <=  w_sel;
            end
          end
        end

        ACCESS: begin
          if (w_access_done) begin
            r_state       <= RESP;
            r_mem_ce_n    <= 1'b1;
            r_mem_oe_n    <= 1'b1;
            r_mem_we_n    <= 1'b1;
            r_mem_data_oe <= 1'b0;
            r_p0_ack      <= ~r_grant;
            r_p1_ack      <=  r_grant;
            r_p0_err      <= ~r_grant & w_timeout;
            r_p1_err      <=  r_grant & w_timeout;
            if (w_capture) begin
              if (r_grant) r_p1_rdata <= mem_rdata;
              else         r_p0_rdata <= mem_rdata;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end

        RESP: begin
          // The ack is visible this cycle; keep its port out of the next IDLE
          // cycle so a req still high from this transaction is not re-granted.
          r_state <= IDLE;
          r_mask  <= r_grant ? 2'b10 : 2'b01;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output ports
  // ---------------------------------------------------------------------------
  assign p0_ack      = r_p0_ack;
  assign p0_err      = r_p0_err;
  assign p0_rdata    = r_p0_rdata;
  assign p1_ack      = r_p1_ack;
  assign p1_err      = r_p1_err;
  assign p1_rdata    = r_p1_rdata;

  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_data_oe = r_mem_data_oe;
  assign mem_ce_n    = r_mem_ce_n;
  assign mem_oe_n    = r_mem_oe_n;
  assign mem_we_n    = r_mem_we_n;
  assign mem_bw      = r_mem_bw;

endmodule
